// File: rtl/led_fade_pwm_pkg.sv
// Shared definitions for the LED fade/PWM stage: brightness width,
// PWM counter terminal value and the brightness level type.
package led_pkg;

   localparam int unsigned LVL_W   = 8;
   localparam int unsigned PWM_MAX = 254;

   typedef logic [LVL_W-1:0] level_t;

endpackage

// File: rtl/led_fade_pwm_if.sv
// Blinker-to-pad bundle: per-LED requests and brightness ceiling in,
// pad drive and ramp status out.
interface led_fade_pwm_if #(
   parameter int unsigned N_CH = 4
);
   import led_pkg::*;

   logic [N_CH-1:0] req;
   level_t          max_level;
   logic [N_CH-1:0] led_out;
   logic [N_CH-1:0] ramp_active;

   modport master (
      output req,
      output max_level,
      input  led_out,
      input  ramp_active
   );

   modport slave (
      input  req,
      input  max_level,
      output led_out,
      output ramp_active
   );

endinterface

// File: rtl/led_fade_pwm_channel.sv
// One LED channel: brightness level ramping toward its target, a duty
// latch refreshed only at PWM wrap, and the PWM compare.
module led_pwm_channel
   import led_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_step_tick,
   input  logic   i_pwm_wrap,
   input  level_t i_pwm_cnt,
   input  logic   i_req,
   input  level_t i_max,
   output logic   o_on,
   output logic   o_ramp_active
);

   level_t r_level;
   level_t r_duty;
   level_t w_tgt;

   assign w_tgt = i_req ? i_max : '0;

   // Step the level one count toward the target; latch duty at period start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_level <= '0;
         r_duty  <= '0;
      end else begin
         if (i_step_tick) begin
            if (r_level < w_tgt) begin
               r_level <= r_level + level_t'(1);
            end else if (r_level > w_tgt) begin
               r_level <= r_level - level_t'(1);
            end
         end
         // Latches the pre-update level when a step lands on the wrap cycle.
         if (i_pwm_wrap) begin
            r_duty <= r_level;
         end
      end
   end

   assign o_on          = (i_pwm_cnt < r_duty);
   assign o_ramp_active = (r_level != w_tgt);

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade PWM top: registers blinker requests and ceiling, generates the
// brightness step prescaler and shared 255-cycle PWM counter, and drives
// the pads with the selected polarity.
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned RAMP_DIV   = 52734,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   led_fade_pwm_if.slave  bus
);

   localparam int unsigned PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [PS_W-1:0] r_ps;
   level_t          r_pwm_cnt;
   logic [N_CH-1:0] r_req_q;
   level_t          r_max_q;
   logic [N_CH-1:0] r_led_out;
   logic [N_CH-1:0] r_ramp_active;

   logic            w_step_tick;
   logic            w_pwm_wrap;
   logic [N_CH-1:0] w_on;
   logic [N_CH-1:0] w_ramp_active;

   assign w_step_tick = (r_ps == PS_W'(RAMP_DIV - 1));
   assign w_pwm_wrap  = (r_pwm_cnt == level_t'(PWM_MAX));

   // Input registers: all downstream logic sees only these copies.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_q <= '0;
         r_max_q <= '0;
      end else begin
         r_req_q <= bus.req;
         r_max_q <= bus.max_level;
      end
   end

   // Brightness step prescaler, 0..RAMP_DIV-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ps <= '0;
      end else if (w_step_tick) begin
         r_ps <= '0;
      end else begin
         r_ps <= r_ps + PS_W'(1);
      end
   end

   // Shared PWM counter, 0..PWM_MAX.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwm_cnt <= '0;
      end else if (w_pwm_wrap) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + level_t'(1);
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      led_pwm_channel u_ch (
         .clk           (clk),
         .rst           (rst),
         .i_step_tick   (w_step_tick),
         .i_pwm_wrap    (w_pwm_wrap),
         .i_pwm_cnt     (r_pwm_cnt),
         .i_req         (r_req_q[gi]),
         .i_max         (r_max_q),
         .o_on          (w_on[gi]),
         .o_ramp_active (w_ramp_active[gi])
      );
   end

   // Output registers: pad polarity applied here, reset leaves LEDs dark.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_led_out     <= {N_CH{ACTIVE_LOW}};
         r_ramp_active <= '0;
      end else begin
         r_led_out     <= w_on ^ {N_CH{ACTIVE_LOW}};
         r_ramp_active <= w_ramp_active;
      end
   end

   assign bus.led_out     = r_led_out;
   assign bus.ramp_active = r_ramp_active;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with RAMP_DIV=4, ACTIVE_LOW=1: a table of
// steady-state {req, max_level} -> per-channel duty vectors, plus hand
// sequences for reset, full ramp timing, reversal and mid-ramp reset.
module tb_led_fade_pwm;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   led_fade_pwm_if #(.N_CH(4)) bus ();

   led_fade_pwm #(
      .N_CH       (4),
      .RAMP_DIV   (4),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]      req;
      logic [7:0]      max;
      logic [3:0][8:0] exp_cnt;
   } vec_t;

   vec_t vt[9];

   function automatic vec_t mk(input logic [3:0] r, input logic [7:0] m,
                               input int e0, input int e1, input int e2, input int e3);
      vec_t v;
      v.req = r;
      v.max = m;
      v.exp_cnt[0] = 9'(e0);
      v.exp_cnt[1] = 9'(e1);
      v.exp_cnt[2] = 9'(e2);
      v.exp_cnt[3] = 9'(e3);
      return v;
   endfunction

   function automatic int lvl(input int ch);
      case (ch)
         0:       return int'(dut.g_ch[0].u_ch.r_level);
         1:       return int'(dut.g_ch[1].u_ch.r_level);
         2:       return int'(dut.g_ch[2].u_ch.r_level);
         default: return int'(dut.g_ch[3].u_ch.r_level);
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      bus.max_level = '0;
      cyc(2);
      rst = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, expected completion");
      n_bad++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int l, prev, t_first, t_full, cnt, err, ra_err, start;
      int low[4];

      vt[0] = mk(4'b0001, 8'd64,  64,   0,   0,   0);
      vt[1] = mk(4'b0001, 8'd255, 255,  0,   0,   0);
      vt[2] = mk(4'b0001, 8'd200, 200,  0,   0,   0);
      vt[3] = mk(4'b0001, 8'd50,  50,   0,   0,   0);
      vt[4] = mk(4'b0001, 8'd0,   0,    0,   0,   0);
      vt[5] = mk(4'b1010, 8'd128, 0,  128,   0, 128);
      vt[6] = mk(4'b1111, 8'd1,   1,    1,   1,   1);
      vt[7] = mk(4'b0110, 8'd254, 0,  254, 254,   0);
      vt[8] = mk(4'b0000, 8'd255, 0,    0,   0,   0);

      // Reset held 3 cycles with all requests on.
      rst = 1'b1;
      bus.req = 4'hF;
      bus.max_level = 8'd255;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst_led_%0d", i), int'(bus.led_out), 'hF);
         chk($sformatf("rst_ra_%0d", i), int'(bus.ramp_active), 0);
      end
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (bus.led_out !== 4'hF) cnt++;
      end
      chk("rst_dark_first_period", cnt, 0);

      // Full ramp 0 -> 255 on channel 0.
      do_reset();
      bus.req = 4'b0001;
      bus.max_level = 8'd255;
      prev = 0; t_first = -1; t_full = -1; err = 0; l = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         l = lvl(0);
         if (l < prev || l > prev + 1) err++;
         if (l != 0 && t_first < 0) t_first = i;
         prev = l;
         if (l == 255) begin
            t_full = i;
            break;
         end
      end
      chk("ramp_reached", l, 255);
      chk("ramp_span", t_full - t_first, 254 * 4);
      chk("ramp_monotonic", err, 0);
      cyc(2);
      chk("ramp_ra_drop", int'(bus.ramp_active[0]), 0);
      cyc(260);
      cnt = 0;
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         if (bus.led_out[0] !== 1'b0) cnt++;
      end
      chk("full_on_period", cnt, 0);

      // Steady-state duty table.
      for (int v = 0; v < 9; v++) begin
         bus.req = vt[v].req;
         bus.max_level = vt[v].max;
         cyc(1400);
         chk($sformatf("vec%0d_ra", v), int'(bus.ramp_active), 0);
         for (int c = 0; c < 4; c++) low[c] = 0;
         for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (bus.led_out[c] === 1'b0) low[c]++;
         end
         for (int c = 0; c < 4; c++)
            chk($sformatf("vec%0d_ch%0d_low", v, c), low[c], int'(vt[v].exp_cnt[c]));
      end

      // Reversal at level 100 on channel 1.
      do_reset();
      bus.req = 4'b0010;
      bus.max_level = 8'd255;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (lvl(1) == 100) break;
      end
      chk("rev_reach100", lvl(1), 100);
      bus.req = 4'b0000;
      cyc(2);
      start = lvl(1);
      chk("rev_nojump", int'(start >= 100 && start <= 101), 1);
      prev = start; err = 0; ra_err = 0; l = start;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         l = lvl(1);
         if (l > prev || prev - l > 1) err++;
         if (l != 0 && bus.ramp_active[1] !== 1'b1) ra_err++;
         prev = l;
         if (l == 0) break;
      end
      chk("rev_reach0", l, 0);
      chk("rev_monotonic", err, 0);
      chk("rev_ra_high", ra_err, 0);
      cyc(2);
      chk("rev_ra_drop", int'(bus.ramp_active[1]), 0);

      // Independence and mid-ramp reset.
      do_reset();
      bus.req = 4'b1010;
      bus.max_level = 8'd255;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (lvl(1) == 80) break;
      end
      chk("ind_ch1", lvl(1), 80);
      chk("ind_ch3", lvl(3), 80);
      chk("ind_ch0", lvl(0), 0);
      chk("ind_ch2", lvl(2), 0);
      chk("ind_ra", int'(bus.ramp_active), 'hA);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_levels", lvl(0) + lvl(1) + lvl(2) + lvl(3), 0);
      chk("mrst_led", int'(bus.led_out), 'hF);
      chk("mrst_ra", int'(bus.ramp_active), 0);
      rst = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
